// File: rtl/draw_arb_pkg.sv
// Shared definitions for the draw-engine arbiter and the controllers that
// feed it: FSM state encoding and default payload widths.
package draw_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_GAP  = 2'd2
    } draw_state_t;

    // Default payload widths shared with the score, hook and object controllers
    localparam int DEF_X_W    = 9;
    localparam int DEF_Y_W    = 8;
    localparam int DEF_TYPE_W = 5;

    // Legal requester count range
    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 8;

    // Width of an index into n entries (at least one bit)
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/draw_request_arbiter_picker.sv
// Round-robin priority picker: returns the first set request bit found by
// scanning ptr, ptr+1, ... and wrapping at N_REQ. Purely combinational.
module rr_priority_picker
    import draw_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    // Candidate index and request bit for each scan offset from ptr
    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            // One extra bit so ptr+offset cannot overflow before the wrap
            assign sum           = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign cand_idx[gi]  = (sum >= (IDX_W + 1)'(N_REQ))
                                 ? IDX_W'(sum - (IDX_W + 1)'(N_REQ))
                                 : sum[IDX_W-1:0];
            assign cand_hit[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Smallest offset with a pending request wins
    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid     = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
        grant_oh = valid ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares one object-drawing engine between N_REQ requesters. Grants round
// robin, latches the granted payload for the whole draw, routes the engine's
// done back to the granted requester only, and force-releases the engine if
// done never arrives within TIMEOUT cycles.
module draw_request_arbiter
    import draw_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int TYPE_W  = DEF_TYPE_W,
    parameter int TIMEOUT = 4096,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req_start,
    input  logic [N_REQ*X_W-1:0]    req_x,
    input  logic [N_REQ*Y_W-1:0]    req_y,
    input  logic [N_REQ*TYPE_W-1:0] req_type,
    output logic [N_REQ-1:0]        req_done,
    output logic                    draw_start,
    output logic [X_W-1:0]          draw_x,
    output logic [Y_W-1:0]          draw_y,
    output logic [TYPE_W-1:0]       draw_type,
    input  logic                    draw_done,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Reject unsupported configurations at elaboration
    generate
        if (N_REQ < MIN_REQ || N_REQ > MAX_REQ) begin : g_bad_n_req
            $error("draw_request_arbiter: N_REQ must be in 2..8");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("draw_request_arbiter: TIMEOUT must be at least 2");
        end
    endgenerate

    draw_state_t      state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [N_REQ-1:0] grant_oh_reg;

    logic             pick_valid;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_next;

    // Unpacked views of the packed per-requester payload buses
    logic [X_W-1:0]    x_arr    [N_REQ];
    logic [Y_W-1:0]    y_arr    [N_REQ];
    logic [TYPE_W-1:0] type_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign x_arr[gi]    = req_x[gi*X_W +: X_W];
            assign y_arr[gi]    = req_y[gi*Y_W +: Y_W];
            assign type_arr[gi] = req_type[gi*TYPE_W +: TYPE_W];
        end
    endgenerate

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (req_start),
        .ptr       (ptr_reg),
        .valid     (pick_valid),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    // Priority moves to the requester just after the one being served
    assign ptr_next = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Arbiter FSM with payload latch and done watchdog; all outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            tmo_cnt_reg  <= '0;
            grant_oh_reg <= '0;
            grant_id     <= '0;
            req_done     <= '0;
            draw_start   <= 1'b0;
            draw_x       <= '0;
            draw_y       <= '0;
            draw_type    <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            req_done <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id     <= pick_idx;
                        grant_oh_reg <= pick_oh;
                        draw_x       <= x_arr[pick_idx];
                        draw_y       <= y_arr[pick_idx];
                        draw_type    <= type_arr[pick_idx];
                        draw_start   <= 1'b1;
                        busy         <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    // Engine finished, or it is presumed stuck: release it either way
                    if (draw_done || tmo_cnt_reg == TMO_LAST) begin
                        draw_start  <= 1'b0;
                        req_done    <= grant_oh_reg;
                        ptr_reg     <= ptr_next;
                        tmo_cnt_reg <= '0;
                        state_reg   <= S_GAP;
                        if (!draw_done) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // draw_start stays low this cycle so the engine re-arms
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    draw_start <= 1'b0;
                    busy       <= 1'b0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed and randomized checks of draw_request_arbiter against a
// transaction-level model (rotating-priority pick, per-grant payload).
module tb_draw_request_arbiter;

    localparam int N    = 4;
    localparam int XW   = 9;
    localparam int YW   = 8;
    localparam int TW   = 5;
    localparam int TO   = 16;
    localparam int IW   = 2;

    logic              clk;
    logic              resetn;
    logic [N-1:0]      req_start;
    logic [N*XW-1:0]   req_x;
    logic [N*YW-1:0]   req_y;
    logic [N*TW-1:0]   req_type;
    logic [N-1:0]      req_done;
    logic              draw_start;
    logic [XW-1:0]     draw_x;
    logic [YW-1:0]     draw_y;
    logic [TW-1:0]     draw_type;
    logic              draw_done;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              timeout_err;

    draw_request_arbiter #(
        .N_REQ   (N),
        .X_W     (XW),
        .Y_W     (YW),
        .TYPE_W  (TW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_start   (req_start),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_type    (req_type),
        .req_done    (req_done),
        .draw_start  (draw_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_type   (draw_type),
        .draw_done   (draw_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [XW-1:0] px [N];
    logic [YW-1:0] py [N];
    logic [TW-1:0] pt [N];
    int            m_ptr  = 0;
    logic          m_terr = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // At most one done bit, and never together with draw_start
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            n_tests++;
            assert ($onehot0(req_done) && !((|req_done) && draw_start)) else begin
                n_fail++;
                $error("FAIL done_excl: observed req_done=%0h draw_start=%0b expected onehot0, no overlap",
                       req_done, draw_start);
            end
        end
    end

    // Rotating priority: first pending index at or after ptr, wrapping
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic apply_payload();
        for (int i = 0; i < N; i++) begin
            req_x[i*XW +: XW] = px[i];
            req_y[i*YW +: YW] = py[i];
            req_type[i*TW +: TW] = pt[i];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, draw_start, 0);
        chk({tag, "_done"},  req_done, 0);
        chk({tag, "_x"},     draw_x, 0);
        chk({tag, "_y"},     draw_y, 0);
        chk({tag, "_type"},  draw_type, 0);
        chk({tag, "_gid"},   grant_id, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_terr"},  timeout_err, 0);
    endtask

    // Called at the negedge before the granting edge. d<0: never send done.
    task automatic serve(input int g, input int d, input bit drop_mid);
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [TW-1:0] et;
        int n;
        ex = px[g]; ey = py[g]; et = pt[g];
        @(negedge clk);
        chk("grant_start", draw_start, 1);
        chk("grant_id", grant_id, g);
        chk("grant_x", draw_x, ex);
        chk("grant_y", draw_y, ey);
        chk("grant_type", draw_type, et);
        chk("grant_busy", busy, 1);
        // Payload changes after the grant must not reach the engine
        px[g] = px[g] + 9'd8;
        py[g] = py[g] + 8'd3;
        pt[g] = pt[g] + 5'd1;
        apply_payload();
        if (drop_mid) req_start[g] = 1'b0;
        n = (d < 0) ? TO - 1 : d;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("hold_start", draw_start, 1);
            chk("hold_x", draw_x, ex);
            chk("hold_nodone", req_done, 0);
        end
        if (d >= 0) draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        m_ptr = (g + 1) % N;
        if (d < 0) m_terr = 1'b1;
        chk("release_done", req_done, 32'(1) << g);
        chk("release_start", draw_start, 0);
        chk("release_busy", busy, 1);
        chk("release_terr", timeout_err, m_terr);
        $display("[TB] draw g=%0d x=%0d y=%0d type=%0d delay=%0d drop=%0b", g, ex, ey, et, d, drop_mid);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", req_done, 0);
        chk("idle_start", draw_start, 0);
    endtask

    int g;
    logic [N-1:0] add;

    initial begin
        resetn    = 1'b0;
        req_start = '0;
        draw_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            px[i] = '0; py[i] = '0; pt[i] = '0;
        end
        apply_payload();
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        m_ptr = 0;

        // 1. Single request
        idle_check();
        px[2] = 9'd51; py[2] = 8'd9; pt[2] = 5'd3; apply_payload();
        req_start[2] = 1'b1;
        serve(2, 4, 1'b0);
        req_start[2] = 1'b0;
        idle_check();

        // 2. Fresh reset, all four held: order 0,1,2,3,0
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            px[i] = 9'(10 * i + 1); py[i] = 8'(20 + i); pt[i] = 5'(i + 7);
        end
        apply_payload();
        req_start = '1;
        serve(0, 0, 1'b0); idle_check();
        serve(1, 0, 1'b0); idle_check();
        serve(2, 0, 1'b0); idle_check();
        serve(3, 0, 1'b0); idle_check();
        serve(0, 0, 1'b0);
        req_start = '0;
        idle_check();

        // 3. Payload change mid-draw: x 59 -> 67 is ignored
        px[1] = 9'd59; apply_payload();
        req_start[1] = 1'b1;
        serve(1, 4, 1'b0);
        chk("payload_next_x", px[1], 67);
        req_start[1] = 1'b0;
        idle_check();

        // 4. Requester drops mid-draw: draw completes and done still pulses
        req_start[0] = 1'b1;
        serve(0, 3, 1'b1);
        req_start[0] = 1'b0;
        idle_check();

        // Randomized rounds against the rotating-priority model
        for (int it = 0; it < 30; it++) begin
            add = N'($urandom_range(0, 15));
            if ((req_start | add) == '0) add = N'(1) << $urandom_range(0, N - 1);
            req_start = req_start | add;
            for (int i = 0; i < N; i++) begin
                px[i] = XW'($urandom); py[i] = YW'($urandom); pt[i] = TW'($urandom);
            end
            apply_payload();
            g = pick(req_start, m_ptr);
            serve(g, int'($urandom_range(0, 10)), ($urandom_range(0, 3) == 0));
            req_start[g] = 1'b0;
            idle_check();
        end
        req_start = '0;

        // draw_done outside DRAW is ignored
        draw_done = 1'b1;
        idle_check();
        idle_check();
        draw_done = 1'b0;

        // 5. Watchdog: no done -> release after TIMEOUT cycles, sticky error
        req_start[3] = 1'b1;
        serve(3, -1, 1'b0);
        req_start[3] = 1'b0;
        idle_check();
        req_start[0] = 1'b1;
        serve(0, 2, 1'b0);
        req_start[0] = 1'b0;
        idle_check();

        // 6. Reset mid-draw with ptr away from 0
        req_start[2] = 1'b1;
        serve(2, 1, 1'b0);
        idle_check();
        @(negedge clk);
        chk("rst6_pre_start", draw_start, 1);
        #2 resetn = 1'b0;
        #1 chk_all_zero("async_rst");
        req_start = '0;
        @(negedge clk);
        chk_all_zero("rst_held");
        resetn = 1'b1;
        m_ptr  = 0;
        m_terr = 1'b0;
        req_start = 4'b1100;
        chk("ptr_after_rst_model", pick(req_start, m_ptr), 2);
        serve(2, 1, 1'b0);
        req_start = '0;
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
